// File: rtl/ram_bist_pkg.sv
// Shared types for the RAM port self-test master.
//   state_t : controller phases IDLE -> WRITE -> READ -> DRAIN -> IDLE
//   mode_t  : test pattern selection codes
package ram_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_ADDR  = 2'b00,  // data = address (zero-extended / truncated)
    MODE_CHECK = 2'b01,  // alternating 0101.. / 1010.. by address parity
    MODE_NADDR = 2'b10,  // data = ~address pattern
    MODE_SEED  = 2'b11   // data = constant seed
  } mode_t;

endpackage

// File: rtl/ram_bist_patgen.sv
// Combinational test pattern generator: pat = f(mode, seed, addr).
// Ports:
//   mode  in  2   pattern selection (mode_t code)
//   seed  in  DW  constant pattern used by MODE_SEED
//   addr  in  AW  address the pattern is generated for
//   pat   out DW  pattern data
module ram_bist_patgen
  import ram_bist_pkg::*;
#(
  parameter int unsigned AW = 1,
  parameter int unsigned DW = 2
) (
  input  logic [1:0]    mode,
  input  logic [DW-1:0] seed,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] pat
);

  logic [DW-1:0] addr_pat;
  logic [DW-1:0] check_base;

  always_comb begin
    // Sized cast zero-extends when DW > AW and truncates when DW < AW.
    addr_pat   = DW'(addr);
    check_base = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      check_base[i] = ((i % 2) == 0);
    end
  end

  always_comb begin
    pat = seed;
    case (mode)
      MODE_ADDR:  pat = addr_pat;
      MODE_CHECK: pat = addr[0] ? ~check_base : check_base;
      MODE_NADDR: pat = ~addr_pat;
      MODE_SEED:  pat = seed;
      default:    pat = seed;
    endcase
  end

endmodule

// File: rtl/ram_port_bist.sv
// Single-port write-then-read self-test master for one port of a RAM.
// Writes pat(a) to every address, reads every address back and compares.
// Ports:
//   clk            in   1     rising-edge clock shared with the RAM port
//   rst_n          in   1     asynchronous active-low reset
//   start          in   1     begin a test (accepted only in IDLE)
//   abort          in   1     synchronous abort, no done pulse
//   mode           in   2     pattern selection, latched at start
//   seed           in   DW    constant pattern for mode 11, latched at start
//   ram_we         out  1     RAM write enable
//   ram_addr       out  AW    RAM address
//   ram_wdata      out  DW    RAM write data
//   ram_rdata      in   DW    RAM registered read data (1 cycle after addr)
//   busy           out  1     test in progress
//   done           out  1     one-cycle end-of-test pulse
//   pass           out  1     no mismatches in last completed test
//   err_cnt        out  AW+1  mismatch count, saturating at DEPTH
//   first_err_addr out  AW    address of first mismatch, 0 if none
module ram_port_bist
  import ram_bist_pkg::*;
#(
  parameter int unsigned AW = 1,
  parameter int unsigned DW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] seed,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_cnt,
  output logic [AW-1:0] first_err_addr
);

  localparam logic [AW-1:0] LAST_ADDR = '1;
  localparam logic [AW:0]   ERR_MAX   = {1'b1, {AW{1'b0}}};

  state_t        state, state_d;
  logic [AW-1:0] cnt, cnt_d;
  mode_t         mode_q, mode_q_d;
  logic [DW-1:0] seed_q, seed_q_d;
  logic          rd_act, rd_act_d;       // ram_addr currently carries a read
  logic          cmp_valid, cmp_valid_d; // ram_rdata holds data for exp_addr
  logic [AW-1:0] exp_addr, exp_addr_d;

  logic          ram_we_d;
  logic [AW-1:0] ram_addr_d;
  logic [DW-1:0] ram_wdata_d;
  logic          busy_d, done_d, pass_d;
  logic [AW:0]   err_cnt_d;
  logic [AW-1:0] first_err_addr_d;

  logic [DW-1:0] wr_pat, exp_pat;
  logic          miss;
  logic [AW:0]   err_upd;
  logic [AW-1:0] first_upd;

  ram_bist_patgen #(.AW(AW), .DW(DW)) u_wr_pat (
    .mode (mode_q),
    .seed (seed_q),
    .addr (cnt),
    .pat  (wr_pat)
  );

  ram_bist_patgen #(.AW(AW), .DW(DW)) u_exp_pat (
    .mode (mode_q),
    .seed (seed_q),
    .addr (exp_addr),
    .pat  (exp_pat)
  );

  // Result update for the compare slot; only committed in active states.
  always_comb begin
    miss      = cmp_valid && (ram_rdata != exp_pat);
    err_upd   = err_cnt;
    first_upd = first_err_addr;
    if (miss) begin
      if (err_cnt != ERR_MAX) begin
        err_upd = err_cnt + (AW+1)'(1);
      end
      if (err_cnt == '0) begin
        first_upd = exp_addr;
      end
    end
  end

  always_comb begin
    state_d          = state;
    cnt_d            = cnt;
    mode_q_d         = mode_q;
    seed_q_d         = seed_q;
    rd_act_d         = 1'b0;
    // Expected address trails the issued read address by one cycle, which
    // is exactly the RAM's registered read latency.
    cmp_valid_d      = rd_act;
    exp_addr_d       = ram_addr;
    ram_we_d         = 1'b0;
    ram_addr_d       = ram_addr;
    ram_wdata_d      = ram_wdata;
    busy_d           = busy;
    done_d           = 1'b0;
    pass_d           = pass;
    err_cnt_d        = err_cnt;
    first_err_addr_d = first_err_addr;

    case (state)
      IDLE: begin
        cmp_valid_d = 1'b0;
        if (start && !abort) begin
          state_d          = WRITE;
          cnt_d            = '0;
          mode_q_d         = mode_t'(mode);
          seed_q_d         = seed;
          err_cnt_d        = '0;
          first_err_addr_d = '0;
          pass_d           = 1'b0;
          busy_d           = 1'b1;
        end
      end
      WRITE: begin
        ram_we_d    = 1'b1;
        ram_addr_d  = cnt;
        ram_wdata_d = wr_pat;
        cnt_d       = cnt + AW'(1);
        if (cnt == LAST_ADDR) begin
          state_d = READ;
        end
      end
      READ: begin
        ram_addr_d       = cnt;
        rd_act_d         = 1'b1;
        cnt_d            = cnt + AW'(1);
        err_cnt_d        = err_upd;
        first_err_addr_d = first_upd;
        if (cnt == LAST_ADDR) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        err_cnt_d        = err_upd;
        first_err_addr_d = first_upd;
        // Finish once the last read has reached the compare slot.
        if (!rd_act) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_upd == '0);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (abort && (state != IDLE)) begin
      state_d          = IDLE;
      ram_we_d         = 1'b0;
      rd_act_d         = 1'b0;
      cmp_valid_d      = 1'b0;
      busy_d           = 1'b0;
      done_d           = 1'b0;
      pass_d           = 1'b0;
      err_cnt_d        = err_cnt;
      first_err_addr_d = first_err_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      mode_q         <= MODE_ADDR;
      seed_q         <= '0;
      rd_act         <= 1'b0;
      cmp_valid      <= 1'b0;
      exp_addr       <= '0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      mode_q         <= mode_q_d;
      seed_q         <= seed_q_d;
      rd_act         <= rd_act_d;
      cmp_valid      <= cmp_valid_d;
      exp_addr       <= exp_addr_d;
      ram_we         <= ram_we_d;
      ram_addr       <= ram_addr_d;
      ram_wdata      <= ram_wdata_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      err_cnt        <= err_cnt_d;
      first_err_addr <= first_err_addr_d;
    end
  end

endmodule

// File: tb/tb_ram_port_bist.sv
// Self-checking bench for ram_port_bist (AW=1, DW=2) with a behavioural
// registered-read RAM that can force selected read bits to 0.
module tb_ram_port_bist;

  localparam int DEPTH = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [1:0] mode;
  logic [1:0] seed;
  logic       ram_we;
  logic [0:0] ram_addr;
  logic [1:0] ram_wdata;
  logic [1:0] ram_rdata;
  logic       busy;
  logic       done;
  logic       pass;
  logic [1:0] err_cnt;
  logic [0:0] first_err_addr;

  ram_port_bist #(.AW(1), .DW(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .mode           (mode),
    .seed           (seed),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: registered read, read bits set in fmask read back as 0.
  logic [1:0] mem   [DEPTH];
  logic [1:0] fmask [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr] & ~fmask[ram_addr];
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model of one complete test.
  function automatic logic [1:0] pat(input logic [1:0] m, input logic [1:0] s, input int a);
    logic [1:0] av;
    av = 2'(a);
    case (m)
      2'b00:   return av;
      2'b01:   return (a % 2 == 0) ? 2'b01 : 2'b10;
      2'b10:   return ~av;
      default: return s;
    endcase
  endfunction

  logic       checking = 1'b0;
  logic       active   = 1'b0;
  int         acc_edge = 0;
  int         exp_err;
  int         exp_first;
  logic       exp_pass;
  logic [2:0] exp_wq[$];
  logic [2:0] obs_q[$];

  // Compare process: DUT outputs against the model, every cycle.
  initial begin
    int k;
    forever begin
      @(negedge clk);
      if (checking) begin
        if (active) begin
          k = edge_cnt - acc_edge;
          if (ram_we) obs_q.push_back({ram_addr, ram_wdata});
          if (k <= 2*DEPTH+1) begin
            chk("busy_run", busy, 1);
            chk("done_early", done, 0);
          end else if (k == 2*DEPTH+2) begin
            chk("done_pulse", done, 1);
            chk("err_cnt_model", err_cnt, exp_err);
            chk("first_err_model", first_err_addr, exp_first);
            chk("pass_model", pass, exp_pass);
            chk("write_count", obs_q.size(), exp_wq.size());
            for (int i = 0; i < exp_wq.size(); i++) begin
              if (i < obs_q.size()) chk("write_stream", obs_q[i], exp_wq[i]);
            end
          end else begin
            chk("busy_after", busy, 0);
            chk("done_after", done, 0);
            active = 1'b0;
          end
        end else begin
          chk("idle_busy", busy, 0);
          chk("idle_done", done, 0);
          chk("idle_we", ram_we, 0);
        end
      end
    end
  end

  task automatic begin_run(input logic [1:0] m, input logic [1:0] s,
                           input logic [1:0] f0, input logic [1:0] f1);
    logic [1:0] p;
    fmask[0] = f0;
    fmask[1] = f1;
    exp_wq.delete();
    obs_q.delete();
    exp_err   = 0;
    exp_first = 0;
    for (int a = 0; a < DEPTH; a++) begin
      p = pat(m, s, a);
      exp_wq.push_back({a[0], p});
      if ((p & ~fmask[a]) != p) begin
        if (exp_err == 0) exp_first = a;
        if (exp_err < DEPTH) exp_err++;
      end
    end
    exp_pass = (exp_err == 0);
    @(negedge clk);
    #1;
    mode     = m;
    seed     = s;
    start    = 1'b1;
    acc_edge = edge_cnt + 1;
    active   = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    // Changing inputs after acceptance must not affect the running test.
    mode  = ~m;
    seed  = ~s;
  endtask

  task automatic finish_run(input int lit_err, input int lit_first, input logic lit_pass);
    for (int i = 0; i < 40 && active; i++) @(negedge clk);
    chk("run_timeout", active, 0);
    #1;
    chk("err_cnt_lit", err_cnt, lit_err);
    chk("first_err_lit", first_err_addr, lit_first);
    chk("pass_lit", pass, lit_pass);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 2'b00;
    seed  = 2'b00;
    fmask[0] = 2'b00;
    fmask[1] = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_first", first_err_addr, 0);
    #1;
    rst_n    = 1'b1;
    checking = 1'b1;

    // Address-as-data, clean RAM: writes 00,01; pass.
    begin_run(2'b00, 2'b00, 2'b00, 2'b00);
    finish_run(0, 0, 1'b1);

    // start held high while busy must not restart or add a done pulse.
    begin_run(2'b00, 2'b00, 2'b00, 2'b00);
    @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 start = 1'b0;
    finish_run(0, 0, 1'b1);

    // Checkerboard, addr1 bit1 stuck at 0: expected 10, read 00.
    begin_run(2'b01, 2'b00, 2'b00, 2'b10);
    finish_run(1, 1, 1'b0);

    // Seed 11, both addresses read 00.
    begin_run(2'b11, 2'b11, 2'b11, 2'b11);
    finish_run(2, 0, 1'b0);

    // Asynchronous reset while writing.
    begin_run(2'b10, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 10 && !ram_we; i++) @(negedge clk);
    chk("t1_we_before", ram_we, 1);
    #1;
    rst_n  = 1'b0;
    active = 1'b0;
    #1;
    chk("t1_we", ram_we, 0);
    chk("t1_busy", busy, 0);
    chk("t1_addr", ram_addr, 0);
    chk("t1_wdata", ram_wdata, 0);
    chk("t1_done", done, 0);
    chk("t1_pass", pass, 0);
    chk("t1_err", err_cnt, 0);
    chk("t1_first", first_err_addr, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Abort during READ (busy with writes finished).
    begin_run(2'b00, 2'b00, 2'b00, 2'b00);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_we) seen = 1'b1;
      else if (seen && busy) break;
    end
    chk("t5_in_read", seen && busy && !ram_we, 1);
    #1;
    abort  = 1'b1;
    active = 1'b0;
    @(negedge clk);
    #1 abort = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_we", ram_we, 0);
    chk("t5_done", done, 0);
    chk("t5_pass", pass, 0);
    chk("t5_err", err_cnt, 0);
    repeat (8) @(negedge clk);
    begin_run(2'b10, 2'b00, 2'b00, 2'b00);
    finish_run(0, 0, 1'b1);

    // start and abort together in IDLE: nothing starts.
    @(negedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_we", ram_we, 0);
    chk("t6_pass_hold", pass, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
